// File: rtl/lzs_pkg.sv
// Shared types and constants for the LZS job arbiter.
// State encoding, data width, and the default word-counter width.
package lzs_pkg;

  localparam int DW            = 64;
  localparam int LZF_WIDTH_DEF = 20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/lzs_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr+1 (mod NCH).
// Zero latency; pure function of req_i and ptr_i.
module lzs_rr_pick #(
  parameter int NCH = 4,
  parameter int CW  = 2
) (
  input  logic [NCH-1:0] req_i,
  input  logic [CW-1:0]  ptr_i,
  output logic [CW-1:0]  grant_o,
  output logic           any_req_o
);

  logic          found;
  logic [CW-1:0] idx;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 1; k <= NCH; k++) begin
      idx = CW'((int'(ptr_i) + k) % NCH);
      if (!found && req_i[idx]) begin
        found   = 1'b1;
        grant_o = idx;
      end
    end
  end

  assign any_req_o = |req_i;

endmodule

// File: rtl/lzs_job_arb.sv
// Whole-job round-robin arbiter sharing one LZS encoder between NCH source FIFOs.
// Grant takes 2 cycles from request (IDLE, GRANT); data path is combinational in RUN; source stalls hold the job.
module lzs_job_arb
  import lzs_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int CW        = 2,
  parameter int LZF_WIDTH = LZF_WIDTH_DEF,
  parameter int DONE_TMO  = 65535
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       ch_en,
  input  logic [NCH-1:0]       ch_src_empty,
  input  logic [DW*NCH-1:0]    ch_fi,
  input  logic [NCH-1:0]       ch_m_last,
  output logic [NCH-1:0]       ch_src_getn,
  output logic [DW-1:0]        enc_fi,
  output logic                 enc_src_empty,
  output logic                 enc_m_last,
  output logic                 enc_ce,
  input  logic                 enc_src_getn,
  input  logic                 enc_valid,
  input  logic                 enc_done,
  output logic [CW-1:0]        cur_chan,
  output logic                 busy,
  output logic [NCH-1:0]       job_done,
  output logic [LZF_WIDTH-1:0] in_cnt,
  output logic [LZF_WIDTH-1:0] out_cnt,
  output logic                 tmo_err
);

  localparam int TW = $clog2(DONE_TMO + 1);

  state_t               state_q, state_d;
  logic [CW-1:0]        ptr_q, ptr_d;
  logic [CW-1:0]        cur_q, cur_d;
  logic [LZF_WIDTH-1:0] in_q, in_d;
  logic [LZF_WIDTH-1:0] out_q, out_d;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic                 err_q, err_d;

  logic [NCH-1:0] req;
  logic [CW-1:0]  pick;
  logic           any_req;
  logic           pop;
  logic [DW-1:0]  fi_arr [NCH];

  for (genvar g = 0; g < NCH; g++) begin : g_fi
    assign fi_arr[g] = ch_fi[DW*g +: DW];
  end

  assign req = ch_en & ~ch_src_empty;

  lzs_rr_pick #(.NCH(NCH), .CW(CW)) u_pick (
    .req_i     (req),
    .ptr_i     (ptr_q),
    .grant_o   (pick),
    .any_req_o (any_req)
  );

  assign pop = (state_q == ST_RUN) && !enc_src_getn && !ch_src_empty[cur_q];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cur_d   = cur_q;
    in_d    = in_q;
    out_d   = out_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = ST_GRANT;
          cur_d   = pick;
        end
      end
      ST_GRANT: begin
        in_d    = '0;
        out_d   = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (pop) begin
          in_d = (&in_q) ? in_q : in_q + 1'b1;
          if (ch_m_last[cur_q]) begin
            state_d = ST_DRAIN;
            tmo_d   = '0;
          end
        end
      end
      ST_DRAIN: begin
        // A done arriving on the expiry cycle still counts as a clean finish.
        if (enc_done) begin
          state_d = ST_DONE;
        end else if (tmo_q == TW'(DONE_TMO - 1)) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_DONE: begin
        ptr_d   = cur_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (enc_valid && (state_q == ST_RUN || state_q == ST_DRAIN)) begin
      out_d = (&out_q) ? out_q : out_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= CW'(NCH - 1);
      cur_q   <= '0;
      in_q    <= '0;
      out_q   <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cur_q   <= cur_d;
      in_q    <= in_d;
      out_q   <= out_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    ch_src_getn   = '1;
    enc_fi        = '0;
    enc_src_empty = 1'b1;
    enc_m_last    = 1'b0;
    enc_ce        = 1'b0;
    job_done      = '0;
    case (state_q)
      ST_RUN: begin
        enc_ce             = 1'b1;
        enc_fi             = fi_arr[cur_q];
        enc_src_empty      = ch_src_empty[cur_q];
        enc_m_last         = ch_m_last[cur_q];
        ch_src_getn[cur_q] = enc_src_getn;
      end
      ST_DRAIN: enc_ce = 1'b1;
      ST_DONE:  job_done[cur_q] = 1'b1;
      default: ;
    endcase
  end

  assign cur_chan = cur_q;
  assign busy     = (state_q == ST_GRANT) || (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign in_cnt   = in_q;
  assign out_cnt  = out_q;
  assign tmo_err  = err_q;

endmodule
